// File: rtl/rr_arbiter_4to4.sv
// rr_arbiter_4to4: round-robin drain of 4 upstream FIFOs (fifo_empty_in/data_inN/valid_in -> fifo_rd_out), routing each word to push_out[dest] with data_out, throttled by pause_in; idle_out/err_out status
module rr_arbiter_4to4 #(
  parameter int DATA_W = 6,
  parameter int DEST_LSB = 4
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [3:0]        fifo_empty_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        valid_in,
  input  logic [3:0]        pause_in,
  output logic [3:0]        fifo_rd_out,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        push_out,
  output logic              idle_out,
  output logic              err_out
);
  typedef enum logic [1:0] {RST, IDLE, RUN, STALL} state_t;
  state_t state, state_n;
  logic [1:0] last_grant, win, tag_idx;
  logic tag_v, can_pop, got, err_n, idle_n;
  logic [3:0] push_n, exp_mask;
  logic [DATA_W-1:0] din [4];
  logic [DATA_W-1:0] word;
  assign din = '{data_in0, data_in1, data_in2, data_in3};
  always_comb begin
    win = last_grant;
    for (int k = 4; k >= 1; k--)
      if (!fifo_empty_in[last_grant + 2'(k)]) win = last_grant + 2'(k);
  end
  assign can_pop = (state == IDLE || state == RUN) && pause_in == '0 && !(&fifo_empty_in);
  assign fifo_rd_out = can_pop ? 4'b0001 << win : '0;
  assign word = din[tag_idx];
  assign got = tag_v && valid_in[tag_idx];
  assign exp_mask = tag_v ? 4'b0001 << tag_idx : '0;
  assign push_n = got ? 4'b0001 << word[DEST_LSB+1:DEST_LSB] : '0;
  // the first cycle after reset may still see a pre-reset pop's valid; it is discarded silently
  assign err_n = state != RST && ((valid_in & ~exp_mask) != '0 || (tag_v && !valid_in[tag_idx]));
  always_comb begin
    state_n = state;
    case (state)
      RST: state_n = IDLE;
      IDLE: state_n = can_pop ? RUN : IDLE;
      RUN, STALL: state_n = |pause_in ? STALL : &fifo_empty_in ? IDLE : RUN;
      default: state_n = RST;
    endcase
  end
  assign idle_n = state_n == IDLE && &fifo_empty_in && push_n == '0;
  always_ff @(posedge clk)
    if (RESET) begin
      state <= RST;
      last_grant <= 2'd3;
      tag_v <= 1'b0;
      tag_idx <= '0;
      data_out <= '0;
      push_out <= '0;
      err_out <= 1'b0;
      idle_out <= 1'b1;
    end else begin
      state <= state_n;
      if (can_pop) last_grant <= win;
      tag_v <= can_pop;
      tag_idx <= win;
      push_out <= push_n;
      if (got) data_out <= word;
      err_out <= err_out | err_n;
      idle_out <= idle_n;
    end
endmodule

// File: tb/tb_rr_arbiter_4to4.sv
// tb_rr_arbiter_4to4: scoreboard bench for rr_arbiter_4to4 with modelled upstream FIFOs
module tb_rr_arbiter_4to4;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic [3:0] fifo_empty_in = 4'hf;
  logic [3:0] valid_in = '0;
  logic [3:0] pause_in = '0;
  logic [5:0] dat [4] = '{default: '0};
  logic [3:0] fifo_rd_out, push_out;
  logic [5:0] data_out;
  logic idle_out, err_out;
  logic [5:0] q [4][$];
  logic [5:0] exp_q [$];
  int nchk = 0, nerr = 0, npush = 0;

  rr_arbiter_4to4 #(.DATA_W(6), .DEST_LSB(4)) dut (
    .clk(clk), .RESET(RESET), .fifo_empty_in(fifo_empty_in),
    .data_in0(dat[0]), .data_in1(dat[1]), .data_in2(dat[2]), .data_in3(dat[3]),
    .valid_in(valid_in), .pause_in(pause_in), .fifo_rd_out(fifo_rd_out),
    .data_out(data_out), .push_out(push_out), .idle_out(idle_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [5:0] w);
    q[i].push_back(w);
    fifo_empty_in[i] = 1'b0;
  endtask

  // one clock: sample pops, model FIFO reads after the edge, score pushes at negedge
  task automatic cyc();
    logic [3:0] rd;
    logic [5:0] e;
    logic p;
    #1 rd = fifo_rd_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      p = rd[i] === 1'b1 && q[i].size() > 0;
      valid_in[i] = p;
      if (p) begin
        dat[i] = q[i].pop_front();
        exp_q.push_back(dat[i]);
      end
      fifo_empty_in[i] = q[i].size() == 0;
    end
    @(negedge clk);
    if (push_out != '0) begin
      npush++;
      if (exp_q.size() == 0) check("spurious push", 32'(push_out), 0);
      else begin
        e = exp_q.pop_front();
        check("push data", 32'(data_out), 32'(e));
        check("push dest", 32'(push_out), 32'(1) << e[5:4]);
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    pause_in = '0;
    cyc();
    check("rst rd", 32'(fifo_rd_out), 0);
    check("rst push", 32'(push_out), 0);
    check("rst data", 32'(data_out), 0);
    check("rst err", 32'(err_out), 0);
    check("rst idle", 32'(idle_out), 1);
    RESET = 1'b0;
    exp_q.delete();
    cyc();
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0 && fifo_empty_in == 4'hf) break;
      cyc();
    end
    check("drain", exp_q.size(), 0);
    cyc();
    cyc();
    check("idle after drain", 32'(idle_out), 1);
  endtask

  initial begin
    int n0, trail;
    // single word to queue 0, dest 2
    do_reset();
    load(0, 6'b10_0101);
    #1;
    check("t1 rd", 32'(fifo_rd_out), 32'b0001);
    cyc();
    check("t1 push n+1", 32'(push_out), 0);
    check("t1 idle n+1", 32'(idle_out), 0);
    cyc();
    check("t1 push n+2", 32'(push_out), 32'b0100);
    check("t1 data n+2", 32'(data_out), 32'h25);
    check("t1 idle n+2", 32'(idle_out), 0);
    cyc();
    check("t1 idle n+3", 32'(idle_out), 1);
    check("t1 push n+3", 32'(push_out), 0);
    // all four queues with 3 words: strict rotation, no bubbles
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) load(i, {2'(i + j), 2'(i), 2'(j)});
    #1;
    n0 = npush;
    for (int k = 0; k < 12; k++) begin
      check("t2 order", 32'(fifo_rd_out), 32'(1) << (k % 4));
      cyc();
    end
    drain();
    check("t2 pushes", npush - n0, 12);
    // pause on queue 1's downstream mid-stream
    do_reset();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) load(i, {2'(3 - i), 2'(j), 2'(i)});
    #1;
    cyc();
    cyc();
    cyc();
    pause_in = 4'b0010;
    #1;
    trail = 0;
    for (int k = 0; k < 5; k++) begin
      check("t3 paused rd", 32'(fifo_rd_out), 0);
      if (push_out != '0) trail++;
      cyc();
    end
    check("t3 trailing pushes", trail, 2);
    pause_in = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (fifo_rd_out != '0) break;
      cyc();
    end
    check("t3 resume queue", 32'(fifo_rd_out), 32'b1000);
    drain();
    // queue 2 alone: back-to-back grants, none once empty
    load(2, 6'h31);
    load(2, 6'h02);
    load(2, 6'h13);
    load(2, 6'h24);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t4 q2 rd", 32'(fifo_rd_out), 32'b0100);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      check("t4 empty rd", 32'(fifo_rd_out), 0);
      cyc();
    end
    drain();
    // unexpected valid: sticky error
    valid_in = 4'b0010;
    cyc();
    check("t5 err set", 32'(err_out), 1);
    load(0, 6'h0a);
    load(1, 6'h1b);
    load(0, 6'h2c);
    load(1, 6'h3d);
    drain();
    check("t5 err held", 32'(err_out), 1);
    do_reset();
    // reset with two words in flight
    load(1, 6'h15);
    load(3, 6'h36);
    #1;
    check("t6 rd q1", 32'(fifo_rd_out), 32'b0010);
    cyc();
    RESET = 1'b1;
    cyc();
    check("t6 push at reset", 32'(push_out), 0);
    RESET = 1'b0;
    exp_q.delete();
    load(2, 6'h27);
    load(3, 6'h08);
    cyc();
    check("t6 first grant", 32'(fifo_rd_out), 32'b0100);
    check("t6 push after reset", 32'(push_out), 0);
    check("t6 err after reset", 32'(err_out), 0);
    cyc();
    check("t6 push after reset 2", 32'(push_out), 0);
    drain();
    check("t6 err clean", 32'(err_out), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
